clk_div_cfg_arbiter: RTL and testbench
======================================

# clk_div_cfg_arbiter

Configuration arbiter and sequencer for the clock divider. Shares one divider among NREQ requesters, each wanting its own decimation ratio and phase delay. It grants one requester at a time in round-robin order and drives the divider's `decimation_ratio`, `delay` and `delay_valid` inputs in a fixed order. It then waits a settle interval and acknowledges the requester.

## Interface

Parameters:
- `NREQ`, default 2: number of requesters, 2..8.
- `SETTLE`, default 4: settle cycles after the delay strobe, 1..255.
- `RESET_RATIO`, default 7'd1: value of `decimation_ratio` out of reset.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  NREQ  request per requester; level-held.
- `req_ratio`  in  7*NREQ  ratio of requester i at bits [7i+6:7i].
- `req_delay`  in  7*NREQ  delay of requester i at bits [7i+6:7i].
- `ack`  out  NREQ  one-cycle pulse; sequence for that requester complete.
- `nack`  out  NREQ  one-cycle pulse; request rejected. Tied 0 unless the macro is enabled.
- `decimation_ratio`  out  7  to the divider.
- `delay`  out  7  to the divider.
- `delay_valid`  out  1  to the divider; one-cycle strobe.
- `busy`  out  1  high whenever state is not IDLE.
- `grant_id`  out  $clog2(NREQ)  index of the current or last granted requester.

## Operation

- All outputs are registered.
- Reset values:
  - `decimation_ratio` = RESET_RATIO.
  - `delay` = 0, `delay_valid` = 0.
  - `ack` = 0, `nack` = 0, `busy` = 0.
  - `grant_id` = 0, round-robin pointer = 0, state = IDLE.
- FSM states: IDLE, LOAD, STROBE, SETTLE, ACK, and NACK (macro only).
- IDLE:
  - If any `req` bit is high, grant the first set bit scanning from the pointer upward, modulo NREQ.
  - Latch that requester's ratio and delay; set `grant_id`.
  - Load `decimation_ratio` with the latched ratio; go to LOAD.
  - Pointer becomes grant+1 mod NREQ.
- LOAD: one cycle. Load `delay` with the latched delay, set `delay_valid`=1; go to STROBE.
- STROBE: `delay_valid` is high for exactly this cycle. Clear it, load the counter with SETTLE-1, go to SETTLE.
- SETTLE: decrement the counter; when it is 0, set `ack[grant_id]`=1 and go to ACK.
- ACK: `ack` is high for exactly this cycle. Clear it; go to IDLE.
- Requester handshake:
  - Hold `req` and stable ratio/delay until `ack` or `nack`.
  - Drop `req` in the cycle after the pulse.
  - `req` values are sampled only in IDLE; changes after the grant are ignored.
  - If `req` drops mid-sequence, the sequence still completes and `ack` is still pulsed.
- `delay` and `decimation_ratio` hold their last programmed value between sequences.
- Simultaneous requests: exactly one is granted per IDLE visit, per the round-robin rule. The others wait. No requester is starved: worst-case wait is NREQ-1 full sequences.

## Timing

- Request first sampled high at IDLE edge E0. Then:
  - `decimation_ratio` is new from cycle 1 (LOAD).
  - `delay_valid`=1 with the new `delay` in cycle 2 (STROBE).
  - SETTLE occupies cycles 3..SETTLE+2.
  - `ack` is high in cycle SETTLE+3.
  - IDLE in cycle SETTLE+4; the earliest next grant is at the end of that cycle.
- `decimation_ratio` always changes at least one cycle before `delay_valid` rises.
- Sequence length is SETTLE+4 cycles, IDLE included.
- `rst` asserted mid-sequence:
  - All outputs return to reset values immediately; no `ack` is issued.
  - A requester still holding `req` is re-granted after `rst` deasserts. Pointer is 0 at that point.
- SETTLE=1: exactly one SETTLE cycle.

## Configuration

- `CFG_REJECT_ZERO_EN` defined:
  - In IDLE, a granted request with ratio 7'd0 goes to NACK instead of LOAD.
  - `nack[grant]` is high for one cycle, the cycle after the grant; then IDLE.
  - `decimation_ratio` and `delay` are unchanged, `delay_valid` stays 0, and the pointer still advances.
- `CFG_REJECT_ZERO_EN` undefined:
  - Ratio 0 is programmed like any other value.
  - NACK state is absent; `nack` is constant 0.

## Test plan

- Reset, then idle 5 cycles: `decimation_ratio`=1, `delay`=0, `delay_valid`=0, `busy`=0, `ack`=0.
- NREQ=2, SETTLE=4. `req[0]` with ratio 10, delay 3, first sampled at edge E0:
  - `decimation_ratio`=10 in cycle 1.
  - `delay_valid`=1 with `delay`=3 in cycle 2 only.
  - `ack[0]` in cycle 7 only.
- `req[0]` and `req[1]` raised in the same cycle after reset:
  - Requester 0 is served first and `ack[0]` pulses.
  - Requester 1 is granted in the next IDLE and `ack[1]` follows SETTLE+4 cycles after `ack[0]`.
  - With both held continuously, grants alternate 0,1,0,1.
- `rst` pulsed during SETTLE:
  - Outputs return to reset values and no `ack` occurs.
  - With `req` held, a full new sequence completes after `rst` falls.
- Macro on, ratio 0 request: `nack` pulses the cycle after the grant, `decimation_ratio` is unchanged, no `delay_valid`. Macro off, same stimulus: `decimation_ratio`=0 and `ack` pulses.

Source files
------------

// File: rtl/clk_div_cfg_arbiter.sv
// clk_div_cfg_arbiter: round-robin arbiter that sequences ratio/delay updates into a shared clock divider.
// Define CFG_REJECT_ZERO_EN to reject ratio-0 requests with a nack pulse instead of programming them.
module clk_div_cfg_arbiter #(
  parameter int         NREQ        = 2,
  parameter int         SETTLE      = 4,
  parameter logic [6:0] RESET_RATIO = 7'd1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [7*NREQ-1:0]       req_ratio,
  input  logic [7*NREQ-1:0]       req_delay,
  output logic [NREQ-1:0]         ack,
  output logic [NREQ-1:0]         nack,
  output logic [6:0]              decimation_ratio,
  output logic [6:0]              delay,
  output logic                    delay_valid,
  output logic                    busy,
  output logic [$clog2(NREQ)-1:0] grant_id
);
  localparam int IW = $clog2(NREQ);
`ifdef CFG_REJECT_ZERO_EN
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_STROBE, S_SETTLE, S_ACK, S_NACK} state_e;
`else
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_STROBE, S_SETTLE, S_ACK} state_e;
`endif
  state_e          state_q;
  logic [IW-1:0]   ptr_q, gnt_q, gnt_d, idx;
  logic [6:0]      ratio_q, delay_q, dly_q, sel_ratio, sel_delay;
  logic [7:0]      cnt_q;
  logic [NREQ-1:0] ack_q, nack_q;
  logic            dv_q, busy_q, any_d;
  // Scan downward so the requester closest above the pointer wins last.
  always_comb begin
    gnt_d = ptr_q;
    any_d = 1'b0;
    idx = '0;
    sel_ratio = '0;
    sel_delay = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = IW'((int'(ptr_q) + k) % NREQ);
      if (req[idx]) begin
        gnt_d = idx;
        any_d = 1'b1;
      end
    end
    for (int k = 0; k < NREQ; k++)
      if (gnt_d == IW'(k)) begin
        sel_ratio = req_ratio[7*k +: 7];
        sel_delay = req_delay[7*k +: 7];
      end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      dly_q   <= '0;
      cnt_q   <= '0;
      ratio_q <= RESET_RATIO;
      delay_q <= '0;
      dv_q    <= 1'b0;
      ack_q   <= '0;
      nack_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      ack_q  <= '0;
      nack_q <= '0;
      dv_q   <= 1'b0;
      case (state_q)
        S_IDLE: if (any_d) begin
          gnt_q  <= gnt_d;
          ptr_q  <= (int'(gnt_d) == NREQ - 1) ? '0 : gnt_d + 1'b1;
          busy_q <= 1'b1;
`ifdef CFG_REJECT_ZERO_EN
          if (sel_ratio == 7'd0) begin
            nack_q[gnt_d] <= 1'b1;
            state_q       <= S_NACK;
          end else
`endif
          begin
            ratio_q <= sel_ratio;
            dly_q   <= sel_delay;
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          delay_q <= dly_q;
          dv_q    <= 1'b1;
          state_q <= S_STROBE;
        end
        S_STROBE: begin
          cnt_q   <= 8'(SETTLE - 1);
          state_q <= S_SETTLE;
        end
        S_SETTLE: if (cnt_q == 8'd0) begin
          ack_q[gnt_q] <= 1'b1;
          state_q      <= S_ACK;
        end else
          cnt_q <= cnt_q - 8'd1;
`ifdef CFG_REJECT_ZERO_EN
        S_NACK: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
`endif
        S_ACK: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  assign ack              = ack_q;
  assign nack             = nack_q;
  assign decimation_ratio = ratio_q;
  assign delay            = delay_q;
  assign delay_valid      = dv_q;
  assign busy             = busy_q;
  assign grant_id         = gnt_q;
endmodule

// File: tb/tb_clk_div_cfg_arbiter.sv
// tb_clk_div_cfg_arbiter: directed checks of grant order, programming timing, reset abort and ratio-0 handling.
module tb_clk_div_cfg_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = '0;
  logic [13:0] req_ratio = '0;
  logic [13:0] req_delay = '0;
  logic [1:0]  ack, nack;
  logic [6:0]  decimation_ratio, delay;
  logic        delay_valid, busy;
  logic [0:0]  grant_id;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  clk_div_cfg_arbiter #(.NREQ(2), .SETTLE(4), .RESET_RATIO(7'd1)) dut (
    .clk(clk), .rst(rst), .req(req), .req_ratio(req_ratio), .req_delay(req_delay),
    .ack(ack), .nack(nack), .decimation_ratio(decimation_ratio), .delay(delay),
    .delay_valid(delay_valid), .busy(busy), .grant_id(grant_id)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask
  // Entered in the cycle whose closing edge grants g; leaves in the following IDLE cycle.
  task automatic seq(input int g, input logic [6:0] r, input logic [6:0] d, input logic [1:0] nxt);
    tick();
    chk("c1_ratio", decimation_ratio, r);
    chk("c1_dv", delay_valid, 0);
    chk("c1_busy", busy, 1);
    chk("c1_grant", grant_id, g);
    tick();
    chk("c2_dv", delay_valid, 1);
    chk("c2_delay", delay, d);
    for (int c = 3; c <= 6; c++) begin
      tick();
      chk("settle_dv", delay_valid, 0);
      chk("settle_ack", ack, 0);
      chk("settle_busy", busy, 1);
    end
    tick();
    chk("ack_pulse", ack, 32'd1 << g);
    chk("ack_nack", nack, 0);
    tick();
    chk("idle_ack", ack, 0);
    chk("idle_busy", busy, 0);
    req = nxt;
  endtask
  initial begin
    tick();
    tick();
    rst = 1'b0;
    repeat (5) tick();
    chk("rst_ratio", decimation_ratio, 1);
    chk("rst_delay", delay, 0);
    chk("rst_dv", delay_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ack", ack, 0);
    chk("rst_nack", nack, 0);
    chk("rst_grant", grant_id, 0);
    req_ratio[6:0] = 7'd10;
    req_delay[6:0] = 7'd3;
    req = 2'b01;
    seq(0, 7'd10, 7'd3, 2'b00);
    tick();
    chk("hold_busy", busy, 0);
    chk("hold_ratio", decimation_ratio, 10);
    chk("hold_delay", delay, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_ratio", decimation_ratio, 1);
    req_ratio = {7'd30, 7'd20};
    req_delay = {7'd6, 7'd5};
    req = 2'b11;
    seq(0, 7'd20, 7'd5, 2'b11);
    seq(1, 7'd30, 7'd6, 2'b11);
    seq(0, 7'd20, 7'd5, 2'b11);
    seq(1, 7'd30, 7'd6, 2'b00);
    tick();
    chk("rr_end_busy", busy, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_ratio[6:0] = 7'd15;
    req_delay[6:0] = 7'd9;
    req = 2'b01;
    repeat (4) tick();
    chk("mid_busy", busy, 1);
    chk("mid_delay", delay, 9);
    rst = 1'b1;
    #1;
    chk("abort_ratio", decimation_ratio, 1);
    chk("abort_delay", delay, 0);
    chk("abort_dv", delay_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_grant", grant_id, 0);
    tick();
    chk("abort_ack", ack, 0);
    tick();
    chk("abort_ack2", ack, 0);
    rst = 1'b0;
    seq(0, 7'd15, 7'd9, 2'b00);
    req_ratio[6:0] = 7'd0;
    req_delay[6:0] = 7'd4;
    req = 2'b01;
`ifdef CFG_REJECT_ZERO_EN
    tick();
    chk("rej_nack", nack, 1);
    chk("rej_ack", ack, 0);
    chk("rej_ratio", decimation_ratio, 15);
    chk("rej_dv", delay_valid, 0);
    chk("rej_busy", busy, 1);
    chk("rej_grant", grant_id, 0);
    tick();
    req = 2'b00;
    chk("rej_nack_off", nack, 0);
    chk("rej_busy_off", busy, 0);
    chk("rej_ratio2", decimation_ratio, 15);
    chk("rej_delay", delay, 9);
    tick();
    chk("rej_dv2", delay_valid, 0);
    chk("rej_busy2", busy, 0);
`else
    seq(0, 7'd0, 7'd4, 2'b00);
    tick();
    chk("zero_nack", nack, 0);
    chk("zero_ratio", decimation_ratio, 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
